truth_table_checker: RTL and testbench

Sequential response checker for 2-input gate primitives, sitting on the opposite end of the stimulus path from the testbench driver. It samples the gate's inputs and output once per valid cycle and compares the output against a parameterised truth table. It counts mismatches and tracks which of the four input combinations have been exercised. It reports a registered pass/fail verdict when coverage completes or a timeout expires.

---
 rtl/truth_table_checker_pkg.sv | 26 ++
 rtl/truth_table_checker_if.sv | 43 ++++
 rtl/truth_table_checker_cov.sv | 46 ++++
 rtl/truth_table_checker.sv | 128 ++++++++++++
 tb/tb_truth_table_checker.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_checker_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_checker_pkg
// Shared types and constants for the 2-input gate response checker.
//   state_t   : checker FSM states (IDLE, RUN, DONE)
//   TT_*      : truth tables, bit i = expected output for input index {a,b}=i
//   expected(): looks up the expected gate output for one input index
// -----------------------------------------------------------------------------
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    function automatic logic expected(input logic [3:0] tt, input logic [1:0] idx);
        return tt[idx];
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// -----------------------------------------------------------------------------
// truth_table_checker_if
// Bundle between the stimulus side (master) and the checker (slave).
//   master -> slave : start, sample_valid, a, b, c
//   slave -> master : busy, done, pass, err_count, coverage,
//                     first_err_valid, first_err_idx, dbg_state
// Handshake: sample_valid is a pure valid qualifier with no ready; the
// checker accepts a, b, c on every rising clk edge where sample_valid=1 and
// the FSM is in RUN, and silently drops samples in IDLE or DONE. start is a
// single-cycle request honoured only in IDLE or DONE.
// -----------------------------------------------------------------------------
interface truth_table_checker_if #(
    parameter int ERR_W = 8
);
    import truth_table_checker_pkg::*;

    logic             start;
    logic             sample_valid;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       coverage;
    logic             first_err_valid;
    logic [1:0]       first_err_idx;
    state_t           dbg_state;

    modport master (
        output start, sample_valid, a, b, c,
        input  busy, done, pass, err_count, coverage,
               first_err_valid, first_err_idx, dbg_state
    );

    modport slave (
        input  start, sample_valid, a, b, c,
        output busy, done, pass, err_count, coverage,
               first_err_valid, first_err_idx, dbg_state
    );

endinterface

// File: rtl/truth_table_checker_cov.sv
// -----------------------------------------------------------------------------
// cov_tracker
// Records which of the four input indices have been sampled during a run.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_clear        : clears coverage (start of a new run)
//   i_sample       : accepted sample this cycle
//   i_idx          : input index {a,b} of the sample
//   o_coverage     : registered coverage bitmap
//   o_all_covered  : coverage including this cycle's sample is complete
// -----------------------------------------------------------------------------
module cov_tracker (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_sample,
    input  logic [1:0] i_idx,
    output logic [3:0] o_coverage,
    output logic       o_all_covered
);

    logic [3:0] r_cov;
    logic [3:0] w_cov_next;

    // The FSM must leave RUN on the same edge the last index is seen, so the
    // flag looks at the updated bitmap rather than the registered one.
    always_comb begin
        w_cov_next = r_cov;
        if (i_sample) begin
            w_cov_next = r_cov | (4'b0001 << i_idx);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cov <= 4'h0;
        end else if (i_clear) begin
            r_cov <= 4'h0;
        end else begin
            r_cov <= w_cov_next;
        end
    end

    assign o_coverage    = r_cov;
    assign o_all_covered = &w_cov_next;

endmodule

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
// Samples a 2-input gate's inputs/output, compares against TRUTH, counts
// mismatches, tracks input coverage and issues a registered pass/fail verdict
// when coverage completes or TIMEOUT RUN cycles elapse.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of truth_table_checker_if (controls + results)
// Parameters: TRUTH (expected table), ERR_W (error counter width),
//             TIMEOUT (max RUN cycles, >= 1)
// -----------------------------------------------------------------------------
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter logic [3:0] TRUTH   = TT_AND,
    parameter int         ERR_W   = 8,
    parameter int         TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_checker_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic             r_first_err_valid;
    logic [1:0]       r_first_err_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_idx;
    logic             w_exp;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_start;
    logic             w_timeout;
    logic [ERR_W-1:0] w_err_next;
    logic [3:0]       w_coverage;
    logic             w_all_covered;

    always_comb begin
        w_idx      = {bus.a, bus.b};
        w_exp      = expected(TRUTH, w_idx);
        w_sample   = (r_state == RUN) && bus.sample_valid;
        // Case inequality so an X/Z on c is flagged rather than masked.
        w_mismatch = w_sample && (bus.c !== w_exp);
        w_start    = (r_state != RUN) && bus.start;
        w_timeout  = (r_cnt == CNT_LAST);
        w_err_next = r_err;
        if (w_mismatch && (r_err != {ERR_W{1'b1}})) begin
            w_err_next = r_err + 1'b1;
        end
    end

    cov_tracker u_cov (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_clear       (w_start),
        .i_sample      (w_sample),
        .i_idx         (w_idx),
        .o_coverage    (w_coverage),
        .o_all_covered (w_all_covered)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err             <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= 2'b00;
            r_cnt             <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_state           <= RUN;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_err             <= '0;
                        r_first_err_valid <= 1'b0;
                        r_first_err_idx   <= 2'b00;
                        r_cnt             <= '0;
                    end
                end
                RUN: begin
                    r_err <= w_err_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mismatch && !r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_idx   <= w_idx;
                    end
                    // Verdict uses the updated counts so a sample on the exit
                    // cycle is part of the result.
                    if (w_all_covered || w_timeout) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0) && w_all_covered;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err;
    assign bus.coverage        = w_coverage;
    assign bus.first_err_valid = r_first_err_valid;
    assign bus.first_err_idx   = r_first_err_idx;
    assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_truth_table_checker
// Directed bench for truth_table_checker: dut0 uses AND/ERR_W=8/TIMEOUT=16,
// dut1 uses AND/ERR_W=2 for the saturation scenario.
// -----------------------------------------------------------------------------
module tb_truth_table_checker;
    import truth_table_checker_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    truth_table_checker_if #(.ERR_W(8)) bus0 ();
    truth_table_checker_if #(.ERR_W(2)) bus1 ();

    truth_table_checker #(.TRUTH(TT_AND), .ERR_W(8), .TIMEOUT(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    truth_table_checker #(.TRUTH(TT_AND), .ERR_W(2), .TIMEOUT(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance one rising edge, then settle 1 time unit
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample0(input logic a, input logic b, input logic c);
        bus0.sample_valid = 1'b1;
        bus0.a = a;
        bus0.b = b;
        bus0.c = c;
        step();
        bus0.sample_valid = 1'b0;
    endtask

    task automatic sample1(input logic a, input logic b, input logic c);
        bus1.sample_valid = 1'b1;
        bus1.a = a;
        bus1.b = b;
        bus1.c = c;
        step();
        bus1.sample_valid = 1'b0;
    endtask

    task automatic start0();
        bus0.start = 1'b1;
        step();
        bus0.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b pass=%b, need 0 0 0", bus0.busy, bus0.done, bus0.pass);
        end
        checks++;
        if (bus0.err_count !== 8'd0 || bus0.coverage !== 4'h0) begin
            errors++;
            $display("FAIL reset_counts: err=%0d cov=%h, need 0 0", bus0.err_count, bus0.coverage);
        end
        checks++;
        if (bus0.first_err_valid !== 1'b0 || bus0.first_err_idx !== 2'b00 || bus0.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_first_err: fev=%b fei=%b st=%0d, need 0 00 IDLE", bus0.first_err_valid, bus0.first_err_idx, bus0.dbg_state);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle_ignores_sample();
        sample0(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus0.err_count !== 8'd0 || bus0.coverage !== 4'h0 || bus0.busy !== 1'b0 || bus0.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL idle_sample: err=%0d cov=%h busy=%b, need 0 0 0", bus0.err_count, bus0.coverage, bus0.busy);
        end
    endtask

    task automatic test_timeout();
        bus0.start = 1'b1;
        step();  // edge S
        bus0.start = 1'b0;
        checks++;
        if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.dbg_state !== RUN) begin
            errors++;
            $display("FAIL timeout_start: busy=%b done=%b, need 1 0", bus0.busy, bus0.done);
        end
        for (int k = 1; k <= 16; k++) begin
            bus0.sample_valid = (k == 1) || (k == 2);
            bus0.a = (k == 2);
            bus0.b = (k == 2);
            bus0.c = (k == 2);
            bus0.start = (k == 5);  // ignored while running
            step();
            bus0.sample_valid = 1'b0;
            bus0.start = 1'b0;
            checks++;
            if (bus0.done !== (k == 16) || bus0.busy !== (k != 16)) begin
                errors++;
                $display("FAIL timeout_cycle%0d: done=%b busy=%b, need %b %b", k, bus0.done, bus0.busy, (k == 16), (k != 16));
            end
            checks++;
            if (bus0.pass === 1'b1 && bus0.done !== 1'b1) begin
                errors++;
                $display("FAIL pass_without_done%0d: pass=%b done=%b, need pass 0", k, bus0.pass, bus0.done);
            end
        end
        checks++;
        if (bus0.coverage !== 4'b1001 || bus0.pass !== 1'b0 || bus0.err_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_result: cov=%b pass=%b err=%0d, need 1001 0 0", bus0.coverage, bus0.pass, bus0.err_count);
        end
        // DONE drops samples
        sample0(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus0.err_count !== 8'd0 || bus0.coverage !== 4'b1001 || bus0.done !== 1'b1) begin
            errors++;
            $display("FAIL done_sample: err=%0d cov=%b done=%b, need 0 1001 1", bus0.err_count, bus0.coverage, bus0.done);
        end
    endtask

    task automatic test_and_exhaustive();
        start0();
        checks++;
        if (bus0.busy !== 1'b1 || bus0.coverage !== 4'h0 || bus0.err_count !== 8'd0 || bus0.done !== 1'b0) begin
            errors++;
            $display("FAIL and_start: busy=%b cov=%h err=%0d done=%b, need 1 0 0 0", bus0.busy, bus0.coverage, bus0.err_count, bus0.done);
        end
        sample0(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus0.coverage !== 4'b0001 || bus0.done !== 1'b0) begin
            errors++;
            $display("FAIL and_s0: cov=%b done=%b, need 0001 0", bus0.coverage, bus0.done);
        end
        sample0(1'b0, 1'b1, 1'b0);
        sample0(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus0.coverage !== 4'b0111 || bus0.done !== 1'b0 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL and_s2: cov=%b done=%b busy=%b, need 0111 0 1", bus0.coverage, bus0.done, bus0.busy);
        end
        sample0(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus0.done !== 1'b1 || bus0.pass !== 1'b1 || bus0.err_count !== 8'd0 || bus0.coverage !== 4'hF) begin
            errors++;
            $display("FAIL and_done: done=%b pass=%b err=%0d cov=%h, need 1 1 0 F", bus0.done, bus0.pass, bus0.err_count, bus0.coverage);
        end
        checks++;
        if (bus0.first_err_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.dbg_state !== DONE) begin
            errors++;
            $display("FAIL and_flags: fev=%b busy=%b, need 0 0", bus0.first_err_valid, bus0.busy);
        end
    endtask

    task automatic test_faulty_gate();
        start0();
        sample0(1'b0, 1'b0, 1'b0);
        sample0(1'b0, 1'b1, 1'b1);  // wrong
        checks++;
        if (bus0.err_count !== 8'd1 || bus0.first_err_valid !== 1'b1 || bus0.first_err_idx !== 2'b01) begin
            errors++;
            $display("FAIL fault_first: err=%0d fev=%b fei=%b, need 1 1 01", bus0.err_count, bus0.first_err_valid, bus0.first_err_idx);
        end
        sample0(1'b1, 1'b0, 1'b0);
        sample0(1'b1, 1'b1, 1'b0);  // wrong, completes coverage
        checks++;
        if (bus0.err_count !== 8'd2 || bus0.first_err_idx !== 2'b01 || bus0.pass !== 1'b0 || bus0.done !== 1'b1) begin
            errors++;
            $display("FAIL fault_done: err=%0d fei=%b pass=%b done=%b, need 2 01 0 1", bus0.err_count, bus0.first_err_idx, bus0.pass, bus0.done);
        end
    endtask

    task automatic test_restart();
        start0();
        checks++;
        if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.err_count !== 8'd0 || bus0.coverage !== 4'h0) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b err=%0d cov=%h, need 1 0 0 0", bus0.busy, bus0.done, bus0.err_count, bus0.coverage);
        end
        checks++;
        if (bus0.first_err_valid !== 1'b0 || bus0.first_err_idx !== 2'b00 || bus0.pass !== 1'b0) begin
            errors++;
            $display("FAIL restart_first: fev=%b fei=%b pass=%b, need 0 00 0", bus0.first_err_valid, bus0.first_err_idx, bus0.pass);
        end
    endtask

    task automatic test_reset_mid_run();
        // still in RUN from the restart
        sample0(1'b1, 1'b0, 1'b1);  // wrong
        checks++;
        if (bus0.err_count !== 8'd1 || bus0.coverage !== 4'b0100 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: err=%0d cov=%b busy=%b, need 1 0100 1", bus0.err_count, bus0.coverage, bus0.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus0.busy !== 1'b0 || bus0.err_count !== 8'd0 || bus0.coverage !== 4'h0 || bus0.first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b err=%0d cov=%h fev=%b, need 0 0 0 0", bus0.busy, bus0.err_count, bus0.coverage, bus0.first_err_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus0.dbg_state !== IDLE || bus0.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_release: state=%0d busy=%b, need IDLE 0", bus0.dbg_state, bus0.busy);
        end
    endtask

    task automatic test_x_saturation();
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        sample1(1'b1, 1'b1, 1'bx);  // X where 1 is expected
        checks++;
        if (bus1.err_count !== 2'd1 || bus1.first_err_idx !== 2'b11 || bus1.first_err_valid !== 1'b1) begin
            errors++;
            $display("FAIL x_sample: err=%0d fei=%b fev=%b, need 1 11 1", bus1.err_count, bus1.first_err_idx, bus1.first_err_valid);
        end
        sample1(1'b0, 1'b0, 1'b1);
        sample1(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus1.err_count !== 2'd3 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL sat_reach: err=%0d done=%b, need 3 0", bus1.err_count, bus1.done);
        end
        sample1(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus1.err_count !== 2'd3 || bus1.done !== 1'b1 || bus1.pass !== 1'b0 || bus1.first_err_idx !== 2'b11) begin
            errors++;
            $display("FAIL sat_hold: err=%0d done=%b pass=%b fei=%b, need 3 1 0 11", bus1.err_count, bus1.done, bus1.pass, bus1.first_err_idx);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus0.sample_valid = 1'b0;
        bus0.a = 1'b0;
        bus0.b = 1'b0;
        bus0.c = 1'b0;
        bus1.start = 1'b0;
        bus1.sample_valid = 1'b0;
        bus1.a = 1'b0;
        bus1.b = 1'b0;
        bus1.c = 1'b0;
        #2;
        test_reset();
        test_idle_ignores_sample();
        test_timeout();
        test_and_exhaustive();
        test_faulty_gate();
        test_restart();
        test_reset_mid_run();
        test_x_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
